// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and access-width decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} lsu_state_e;

  function automatic logic is_half(input logic we, input logic [2:0] f3);
    return we ? (f3[1:0] == F3_SH[1:0]) : (f3 == F3_LH || f3 == F3_LHU);
  endfunction

  // Unlisted load codes behave as LW; store widths 10/11 are both word.
  function automatic logic is_word(input logic we, input logic [2:0] f3);
    return we ? f3[1]
              : !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LBU || f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: little-endian extract/extend for loads and
// sub-word merge into the previously read word for stores.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_word_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{addr_i, 3'b000} +: 8];
    half_v = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   load_data_o = {{16{half_v[15]}}, half_v};
      F3_LBU:  load_data_o = {24'h0, byte_v};
      F3_LHU:  load_data_o = {16'h0, half_v};
      default: load_data_o = word_i;
    endcase
  end

  always_comb begin
    merged_word_o = word_i;
    case (funct3_i[1:0])
      F3_SB[1:0]: merged_word_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_SH[1:0]: merged_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:    merged_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer for a word-only DRAM (read-modify-write for SB/SH).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses via err_o.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] dram_addr_o,
  output logic              dram_memwr_o,
  output logic [31:0]       dram_wr_data_o,
  input  logic [31:0]       dram_rd_data_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              mis_req;
  logic [31:0]       load_data, merged_word, rdata_done;

  lsu_lane u_lane (
    .word_i        (word_q),
    .addr_i        (addr_q[1:0]),
    .funct3_i      (funct3_q),
    .wdata_i       (wdata_q),
    .load_data_o   (load_data),
    .merged_word_o (merged_word)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis_req = (is_half(we_i, funct3_i) && addr_i[0]) ||
              (is_word(we_i, funct3_i) && (addr_i[1:0] != 2'b00));
  end
`else
  assign mis_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
    end
  end

  // A trapped access never reads DRAM, so its result is forced to zero.
  assign rdata_done = mis_q ? 32'h0 : load_data;

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    if (state_q == ST_IDLE && req_i) begin
      we_d     = we_i;
      funct3_d = funct3_i;
      addr_d   = addr_i;
      wdata_d  = wdata_i;
      mis_d    = mis_req;
    end
    if (state_q == ST_RD) word_d = dram_rd_data_i;
    if (state_q == ST_DONE) rdata_d = rdata_done;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_i) state_d = mis_req ? ST_DONE : ST_RD;
      ST_RD:   state_d = (!we_q || is_word(1'b1, funct3_q)) ? ST_DONE : ST_WR;
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != ST_IDLE);
    done_o         = (state_q == ST_DONE);
    rdata_o        = (state_q == ST_DONE) ? rdata_done : rdata_q;
    err_o          = 1'b0;
    dram_addr_o    = '0;
    dram_memwr_o   = 1'b0;
    dram_wr_data_o = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    err_o          = (state_q == ST_DONE) && mis_q;
`endif
    unique case (state_q)
      ST_RD: begin
        dram_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
        if (we_q && is_word(1'b1, funct3_q)) begin
          dram_memwr_o   = 1'b1;
          dram_wr_data_o = wdata_q;
        end
      end
      ST_WR: begin
        dram_addr_o    = {addr_q[ADDR_W-1:2], 2'b00};
        dram_memwr_o   = 1'b1;
        dram_wr_data_o = merged_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural word DRAM.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        busy_o, done_o, err_o, dram_memwr_o;
  logic [31:0] rdata_o, dram_addr_o, dram_wr_data_o, dram_rd_data_i;

  logic [31:0] mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .we_i           (we_i),
    .funct3_i       (funct3_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .rdata_o        (rdata_o),
    .err_o          (err_o),
    .dram_addr_o    (dram_addr_o),
    .dram_memwr_o   (dram_memwr_o),
    .dram_wr_data_o (dram_wr_data_o),
    .dram_rd_data_i (dram_rd_data_i)
  );

  always #5 clk = ~clk;

  assign dram_rd_data_i = mem[dram_addr_o[15:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (dram_memwr_o) mem[dram_addr_o[15:2]] <= dram_wr_data_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = a[15:2]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // exp_wr_at = cycle after accept in which memwr is high (0 = never).
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_done,
                        input int exp_wr_at, input logic [31:0] exp_rd, input logic exp_err);
    int done_at, wr_at, wr_n;
    logic [31:0] rd;
    logic er;
    rd = '0; er = 1'b0; done_at = 0; wr_at = 0; wr_n = 0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    req_i = 1'b0;
    for (int c = 1; c <= 6 && done_at == 0; c++) begin
      if (dram_memwr_o) begin wr_n++; wr_at = c; end
      if (done_o) begin
        done_at = c; rd = rdata_o; er = err_o;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, ".done_at"}, done_at, exp_done);
    check({tag, ".wr_at"}, wr_at, exp_wr_at);
    check({tag, ".wr_n"}, wr_n, (exp_wr_at != 0) ? 1 : 0);
    check({tag, ".err"}, {31'h0, er}, {31'h0, exp_err});
    if (done_at != 0) begin
      @(posedge clk); #1;
      check({tag, ".busy_idle"}, {31'h0, busy_o}, 32'h0);
      if (!we) begin
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".rdata_hold"}, rdata_o, exp_rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    #1;
    check("rst.ctl", {28'h0, busy_o, done_o, err_o, dram_memwr_o}, 32'h0);
    check("rst.rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    preload(32'h100, 32'h8899AABB);

    run_op("lb101",  1'b0, 3'b000, 32'h101, 32'h0, 2, 0, 32'hFFFFFFAA, 1'b0);
    run_op("lbu101", 1'b0, 3'b100, 32'h101, 32'h0, 2, 0, 32'h000000AA, 1'b0);
    run_op("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 2, 0, 32'hFFFF8899, 1'b0);
    run_op("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 2, 0, 32'h00008899, 1'b0);
    run_op("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 2, 0, 32'h8899AABB, 1'b0);
    run_op("lb100",  1'b0, 3'b000, 32'h100, 32'h0, 2, 0, 32'hFFFFFFBB, 1'b0);
    run_op("lh100",  1'b0, 3'b001, 32'h100, 32'h0, 2, 0, 32'hFFFFAABB, 1'b0);

    run_op("sb103",  1'b1, 3'b000, 32'h103, 32'h11, 3, 2, 32'h0, 1'b0);
    check("sb103.mem", mem[32'h100 >> 2], 32'h1199AABB);
    run_op("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 2, 0, 32'h00000011, 1'b0);

    preload(32'h100, 32'h8899AABB);
    run_op("sh102",  1'b1, 3'b001, 32'h102, 32'hFFFF5566, 3, 2, 32'h0, 1'b0);
    check("sh102.mem", mem[32'h100 >> 2], 32'h5566AABB);
    preload(32'h100, 32'h8899AABB);

`ifdef LSU_MISALIGN_TRAP_EN
    run_op("lw102",  1'b0, 3'b010, 32'h102, 32'h0, 1, 0, 32'h0, 1'b1);
    run_op("sw102",  1'b1, 3'b010, 32'h102, 32'h0BADF00D, 1, 0, 32'h0, 1'b1);
    check("sw102.mem", mem[32'h100 >> 2], 32'h8899AABB);
`else
    run_op("lw102",  1'b0, 3'b010, 32'h102, 32'h0, 2, 0, 32'h8899AABB, 1'b0);
`endif

    run_op("sw200",  1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 2, 1, 32'h0, 1'b0);
    check("sw200.mem", mem[32'h200 >> 2], 32'hDEADBEEF);
    run_op("lw200",  1'b0, 3'b010, 32'h200, 32'h0, 2, 0, 32'hDEADBEEF, 1'b0);

    // SH aborted by reset during WR, before the write edge.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h100; wdata_i = 32'h1234;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    check("abort.wr_state", {31'h0, dram_memwr_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort.ctl", {28'h0, busy_o, done_o, err_o, dram_memwr_o}, 32'h0);
    check("abort.rdata", rdata_o, 32'h0);
    check("abort.addr", dram_addr_o, 32'h0);
    check("abort.wdata", dram_wr_data_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort.mem", mem[32'h100 >> 2], 32'h8899AABB);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort.no_done", {30'h0, busy_o, done_o}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the single-cycle core's execute stage and the 64 KB word-organised data DRAM. The DRAM only stores whole 32-bit words: it reads asynchronously, writes synchronously, and has no byte enables. This block issues the DRAM accesses for every RV32I load and store. It extracts and extends sub-word load data, performs read-modify-write for SB/SH, and returns a registered result with a done pulse.

## Interface
Parameters:
- ADDR_W, 32, byte address width presented to the DRAM port.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  access request; sampled only while busy_o=0.
- we_i  in  1  1=store, 0=load.
- funct3_i  in  3  RV32I width/sign code.
- addr_i  in  32  byte address from ALU.
- wdata_i  in  32  store data (rs2).
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result; valid when done_o=1 and held until the next done_o.
- err_o  out  1  misalign pulse, coincident with done_o (macro-dependent).
- dram_addr_o  out  32  to DRAM addr_i; word index taken from [15:2] by the DRAM.
- dram_memwr_o  out  1  to DRAM memwr_i.
- dram_wr_data_o  out  32  to DRAM wr_data_i.
- dram_rd_data_i  in  32  from DRAM rd_data_o (async read).

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: if req_i is high, latch we, funct3, addr, wdata, then go to RD. Otherwise stay in IDLE.
- RD: dram_addr_o = {addr_q[31:2],2'b00}. Capture dram_rd_data_i into word_q.
  - Load: go to DONE.
  - SW: dram_memwr_o=1 and dram_wr_data_o=wdata_q, then go to DONE.
  - SB/SH: go to WR.
- WR: dram_memwr_o=1. dram_wr_data_o = word_q with lane(s) addr_q[1:0] replaced by wdata_q[7:0] or wdata_q[15:0]. Go to DONE.
- DONE: done_o=1. rdata_o updates from word_q (extract + extend). Go to IDLE.
- Load decode (funct3): 000 LB sign, 001 LH sign, 100 LBU zero, 101 LHU zero, any other value behaves as LW.
- Store width from funct3[1:0]: 00 byte, 01 half, others word.
- Byte lane = addr_q[1:0]. Halfword lane = addr_q[1]. Little-endian.
- dram_memwr_o is combinational from state. It is never high in IDLE or DONE.

## Timing
- Request accepted at edge E0. RD is the cycle after E0.
- Load and SW: done_o high in the 2nd cycle after E0.
- SB/SH: done_o high in the 3rd cycle after E0.
- The DRAM write commits at the edge ending RD (SW) or WR (SB/SH).
- Next request can be accepted at the edge ending DONE+1 (IDLE). req_i is ignored while busy_o=1.
- Reset values: state IDLE, busy_o 0, done_o 0, err_o 0, rdata_o 0, dram_memwr_o 0, dram_addr_o 0, dram_wr_data_o 0, all latches 0.
- Reset mid-operation:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - An SB/SH whose WR edge has not occurred performs no write.
  - No done_o is produced for the aborted access.
- Sub-word store never corrupts untouched lanes. The merge uses only word_q captured in RD.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned request goes IDLE→DONE directly.
  - No write is performed. err_o=1 with done_o. rdata_o=0.
- Undefined:
  - err_o is tied 0.
  - Halfword accesses use addr[1] only and word accesses ignore addr[1:0], i.e. the address is aligned down.

## Structure
- Shared package lsu_pkg:
  - funct3 constants (F3_LB/LH/LW/LBU/LHU/SB/SH/SW).
  - State enum (ST_IDLE, ST_RD, ST_WR, ST_DONE).
- Sub-module lsu_lane: combinational lane logic, extract+extend for loads and merge for stores.
  - Inputs: word, addr[1:0], funct3, wdata.
  - Outputs: load_data, merged_word.

## Test plan
- Preload word 0x8899AABB at 0x100. LB at 0x101 → rdata_o=0xFFFFFFAA, done_o 2 cycles after accept; LBU same address → 0x000000AA.
- Same word. LH at 0x102 → 0xFFFF8899; LHU → 0x00008899; LW → 0x8899AABB.
- Same word. SB 0x11 at 0x103 → DRAM word 0x1199AABB, memwr high exactly one cycle (WR), done_o 3 cycles after accept.
- SW 0xDEADBEEF at 0x200 → memwr in RD only, done_o at cycle 2; subsequent LW returns 0xDEADBEEF.
- SH 0x1234 at 0x100, rst asserted during WR before its edge → word stays 0x8899AABB, all outputs 0, state IDLE.
- Macro defined: LW at 0x102 → err_o=done_o=1 at cycle 1, rdata_o=0, no write. Macro undefined: same LW → 0x8899AABB, err_o=0.
